// File: rtl/tweezer_dac_writer_if.sv
// Sample bus from the tweezer feedback controller plus the serial DAC pins
// and status flags of tweezer_dac_writer.
interface tweezer_dac_writer_if #(
  parameter int dataBitSize = 16
);
  logic                   enable;
  logic [dataBitSize-1:0] inData;
  logic                   inData_valid;
  logic                   dac_cs_n;
  logic                   dac_sclk;
  logic                   dac_sdi;
  logic                   dac_ldac_n;
  logic                   busy;
  logic                   overrun;

  modport master (
    output enable, inData, inData_valid,
    input  dac_cs_n, dac_sclk, dac_sdi, dac_ldac_n, busy, overrun
  );

  modport slave (
    input  enable, inData, inData_valid,
    output dac_cs_n, dac_sclk, dac_sdi, dac_ldac_n, busy, overrun
  );
endinterface

// File: rtl/tweezer_dac_writer.sv
// Serial DAC transmitter: converts controller samples to offset binary, shifts them
// MSB-first into a 16-bit SPI DAC and pulses LDAC; one-deep pending slot with overrun flag.
module tweezer_dac_writer #(
  parameter int dataBitSize  = 16,
  parameter int clkDivider   = 4,
  parameter int gapCycles    = 2,
  parameter bit offsetBinary = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  tweezer_dac_writer_if.slave  bus
);
  localparam int CntMax = (2 * clkDivider > gapCycles) ? 2 * clkDivider : gapCycles;
  localparam int CntW   = $clog2(CntMax + 1);
  localparam int BitW   = $clog2(dataBitSize + 1);

  localparam logic [CntW-1:0] DivCnt     = CntW'(clkDivider);
  localparam logic [CntW-1:0] DivLast    = CntW'(clkDivider - 1);
  localparam logic [CntW-1:0] PeriodLast = CntW'(2 * clkDivider - 1);
  localparam logic [CntW-1:0] GapLast    = CntW'(gapCycles - 1);
  localparam logic [BitW-1:0] BitLast    = BitW'(dataBitSize - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, LOAD, GAP} state_t;

  state_t                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [BitW-1:0]        bit_q, bit_d;
  logic [dataBitSize-1:0] shreg_q, shreg_d;
  logic [dataBitSize-1:0] pend_word_q, pend_word_d;
  logic                   pend_q, pend_d;

  logic cs_n_q, cs_n_d;
  logic sclk_q, sclk_d;
  logic sdi_q, sdi_d;
  logic ldac_n_q, ldac_n_d;
  logic busy_q, busy_d;
  logic overrun_q, overrun_d;

  logic                   accept;
  logic [dataBitSize-1:0] in_word;

  assign accept  = bus.enable & bus.inData_valid;
  assign in_word = offsetBinary ? {~bus.inData[dataBitSize-1], bus.inData[dataBitSize-2:0]}
                                : bus.inData;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      shreg_q     <= '0;
      pend_word_q <= '0;
      pend_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      sclk_q      <= 1'b0;
      sdi_q       <= 1'b0;
      ldac_n_q    <= 1'b1;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      pend_word_q <= pend_word_d;
      pend_q      <= pend_d;
      cs_n_q      <= cs_n_d;
      sclk_q      <= sclk_d;
      sdi_q       <= sdi_d;
      ldac_n_q    <= ldac_n_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    pend_word_d = pend_word_q;
    pend_d      = pend_q;
    overrun_d   = 1'b0;

    // Disabling silently drops whatever is waiting; it is not an overrun.
    if (!bus.enable) pend_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        if (accept) begin
          shreg_d = in_word;
          state_d = SETUP;
          if (pend_q) begin
            pend_d    = 1'b0;
            overrun_d = 1'b1;
          end
        end else if (pend_q && bus.enable) begin
          shreg_d = pend_word_q;
          pend_d  = 1'b0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == DivLast) begin
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        cnt_d = cnt_q + 1'b1;
        // The high-to-low SCLK edge is where the next bit is presented.
        if (cnt_q == DivLast) shreg_d = {shreg_q[dataBitSize-2:0], 1'b0};
        if (cnt_q == PeriodLast) begin
          cnt_d = '0;
          if (bit_q == BitLast) state_d = LOAD;
          else                  bit_d   = bit_q + 1'b1;
        end
      end
      LOAD: begin
        if (cnt_q == DivLast) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GapLast) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && accept) begin
      pend_word_d = in_word;
      pend_d      = 1'b1;
      if (pend_q) overrun_d = 1'b1;
    end
  end

  // Pin values are decoded from the next state so every output leaves a flop.
  always_comb begin
    cs_n_d   = 1'b1;
    sclk_d   = 1'b0;
    sdi_d    = 1'b0;
    ldac_n_d = 1'b1;
    busy_d   = (state_d != IDLE);
    case (state_d)
      SETUP: begin
        cs_n_d = 1'b0;
        sdi_d  = shreg_d[dataBitSize-1];
      end
      SHIFT: begin
        cs_n_d = 1'b0;
        sdi_d  = shreg_d[dataBitSize-1];
        sclk_d = (cnt_d < DivCnt);
      end
      LOAD:    ldac_n_d = 1'b0;
      default: ;
    endcase
  end

  assign bus.dac_cs_n   = cs_n_q;
  assign bus.dac_sclk   = sclk_q;
  assign bus.dac_sdi    = sdi_q;
  assign bus.dac_ldac_n = ldac_n_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_tweezer_dac_writer.sv
// Bench for tweezer_dac_writer: three configurations share one stimulus stream and are
// checked against a frame-timing reference model and a pin-level frame decoder.
module tb_tweezer_dac_writer;
  localparam int N  = 16;
  localparam int NI = 3;
  localparam int CFG_D [NI] = '{4, 4, 1};
  localparam int CFG_G [NI] = '{2, 2, 1};
  localparam bit CFG_OB[NI] = '{1'b1, 1'b0, 1'b1};
  localparam logic [N-1:0] MSB_MASK  = {1'b1, {(N-1){1'b0}}};
  localparam longint       RST_PINS  = 64'b100100;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en  = 1'b0;
  logic         vld = 1'b0;
  logic [N-1:0] din = '0;
  int           cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic cs_n_w [NI];
  logic sclk_w [NI];
  logic sdi_w  [NI];
  logic ldac_w [NI];
  logic busy_w [NI];
  logic ovr_w  [NI];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    tweezer_dac_writer_if #(.dataBitSize(N)) bus ();
    assign bus.enable       = en;
    assign bus.inData       = din;
    assign bus.inData_valid = vld;
    tweezer_dac_writer #(
      .dataBitSize (N),
      .clkDivider  ((gi == 2) ? 1 : 4),
      .gapCycles   ((gi == 2) ? 1 : 2),
      .offsetBinary((gi == 1) ? 1'b0 : 1'b1)
    ) dut (
      .clk  (clk),
      .reset(rst),
      .bus  (bus.slave)
    );
    assign cs_n_w[gi] = bus.dac_cs_n;
    assign sclk_w[gi] = bus.dac_sclk;
    assign sdi_w[gi]  = bus.dac_sdi;
    assign ldac_w[gi] = bus.dac_ldac_n;
    assign busy_w[gi] = bus.busy;
    assign ovr_w[gi]  = bus.overrun;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input int inst, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s[%0d] cyc=%0d got=0x%0h expected=0x%0h", tag, inst, cyc, got, exp);
    end
  endtask

  function automatic longint pins(input int i);
    return {58'd0, cs_n_w[i], sclk_w[i], sdi_w[i], ldac_w[i], busy_w[i], ovr_w[i]};
  endfunction

  // Reference model: a frame started at edge e occupies the writer until edge e+L,
  // so the earliest next start is edge e+L+1; one newest sample may wait meanwhile.
  int           free_edge [NI];
  bit           pend_v    [NI];
  logic [N-1:0] pend_w    [NI];
  int           start_q   [NI][$];
  logic [N-1:0] word_q    [NI][$];
  int           ov_q      [NI][$];

  function automatic int flen(input int i);
    return CFG_D[i] * (2 * N + 2) + CFG_G[i];
  endfunction

  task automatic frame_start(input int i, input int e, input logic [N-1:0] w);
    start_q[i].push_back(e);
    word_q[i].push_back(w);
    free_edge[i] = e + flen(i) + 1;
  endtask

  task automatic model_step(input int e);
    for (int i = 0; i < NI; i++) begin
      logic [N-1:0] w;
      bit take;
      w    = CFG_OB[i] ? (din ^ MSB_MASK) : din;
      take = en && vld;
      if (!en) pend_v[i] = 1'b0;
      if (e >= free_edge[i]) begin
        if (take) begin
          if (pend_v[i]) ov_q[i].push_back(e);
          pend_v[i] = 1'b0;
          frame_start(i, e, w);
        end else if (pend_v[i]) begin
          pend_v[i] = 1'b0;
          frame_start(i, e, pend_w[i]);
        end
      end else if (take) begin
        if (pend_v[i]) ov_q[i].push_back(e);
        pend_v[i] = 1'b1;
        pend_w[i] = w;
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      start_q[i].delete();
      word_q[i].delete();
      ov_q[i].delete();
      pend_v[i]    = 1'b0;
      free_edge[i] = 0;
    end
  endtask

  // Pin decoder state
  bit           prev_cs   [NI];
  bit           prev_sclk [NI];
  bit           prev_sdi  [NI];
  bit           prev_ldac [NI];
  bit           prev_busy [NI];
  int           sdi_age   [NI];
  int           rise_cyc  [NI];
  int           cs_rise   [NI];
  int           ldac_fall [NI];
  int           busy_start[NI];
  int           nbits     [NI];
  logic [N-1:0] word      [NI];

  task automatic monitor();
    for (int i = 0; i < NI; i++) begin
      bit exp_ov;
      if (rst) begin
        chk("reset_pins", i, pins(i), RST_PINS);
        prev_cs[i] = 1'b1; prev_sclk[i] = 1'b0; prev_sdi[i] = 1'b0;
        prev_ldac[i] = 1'b1; prev_busy[i] = 1'b0;
        sdi_age[i] = 0; cs_rise[i] = -1; nbits[i] = 0; word[i] = '0;
        continue;
      end
      if (sdi_w[i] != prev_sdi[i]) begin
        sdi_age[i] = 1;
        if (!cs_n_w[i]) chk("sdi_change_sclk_low", i, sclk_w[i], 0);
      end else begin
        sdi_age[i]++;
      end
      if (prev_cs[i] && !cs_n_w[i]) begin
        if (start_q[i].size() == 0) chk("cs_fall_unexpected", i, cyc, -1);
        else                        chk("cs_fall_cyc", i, cyc, start_q[i].pop_front());
        nbits[i] = 0;
        word[i]  = '0;
      end
      if (!prev_sclk[i] && sclk_w[i]) begin
        rise_cyc[i] = cyc;
        chk("sclk_in_frame", i, cs_n_w[i], 0);
        chk("sdi_setup", i, sdi_age[i] > CFG_D[i], 1);
        word[i] = {word[i][N-2:0], sdi_w[i]};
        nbits[i]++;
      end
      if (prev_sclk[i] && !sclk_w[i]) chk("sclk_high_len", i, cyc - rise_cyc[i], CFG_D[i]);
      if (!prev_cs[i] && cs_n_w[i]) begin
        cs_rise[i] = cyc;
        chk("nbits", i, nbits[i], N);
        if (word_q[i].size() == 0) chk("word_unexpected", i, word[i], 64'h1_0000);
        else                       chk("word", i, word[i], word_q[i].pop_front());
      end
      if (prev_ldac[i] && !ldac_w[i]) begin
        ldac_fall[i] = cyc;
        chk("ldac_with_cs_rise", i, cyc, cs_rise[i]);
      end
      if (!prev_ldac[i] && ldac_w[i]) chk("ldac_len", i, cyc - ldac_fall[i], CFG_D[i]);
      if (!prev_busy[i] && busy_w[i]) begin
        busy_start[i] = cyc;
        chk("busy_with_cs", i, cs_n_w[i], 0);
      end
      if (prev_busy[i] && !busy_w[i]) chk("busy_len", i, cyc - busy_start[i], flen(i));
      exp_ov = (ov_q[i].size() > 0) && (ov_q[i][0] == cyc);
      if (exp_ov) void'(ov_q[i].pop_front());
      if (exp_ov || ovr_w[i]) chk("overrun", i, ovr_w[i], exp_ov);
      prev_cs[i]   = cs_n_w[i];
      prev_sclk[i] = sclk_w[i];
      prev_sdi[i]  = sdi_w[i];
      prev_ldac[i] = ldac_w[i];
      prev_busy[i] = busy_w[i];
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
  endtask

  task automatic drive(input bit en_i, input bit v_i, input logic [N-1:0] d_i);
    tick();
    en  = en_i;
    vld = v_i;
    din = d_i;
    model_step(cyc + 1);
  endtask

  task automatic idle(input int n, input bit en_i);
    repeat (n) drive(en_i, 1'b0, din);
  endtask

  task automatic do_reset();
    vld = 1'b0;
    #2 rst = 1'b1;
    model_reset();
    #1;
    for (int i = 0; i < NI; i++) chk("reset_now", i, pins(i), RST_PINS);
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
    idle(5, 1'b1);

    drive(1'b1, 1'b1, 16'h1234);
    idle(160, 1'b1);

    drive(1'b1, 1'b1, 16'h8000);
    idle(19, 1'b1);
    drive(1'b1, 1'b1, 16'h7FFF);
    idle(300, 1'b1);

    // second strobe lands on the last GAP cycle of the default frame
    drive(1'b1, 1'b1, 16'hA5A5);
    idle(137, 1'b1);
    drive(1'b1, 1'b1, 16'h5A5A);
    idle(300, 1'b1);

    for (int k = 1; k <= 3; k++) begin
      drive(1'b1, 1'b1, 16'(k));
      idle(9, 1'b1);
    end
    idle(300, 1'b1);

    drive(1'b1, 1'b1, 16'h1111);
    idle(9, 1'b1);
    drive(1'b1, 1'b1, 16'h2222);
    idle(5, 1'b0);
    repeat (6) begin
      drive(1'b0, 1'b1, 16'($urandom));
      idle(49, 1'b0);
    end
    idle(20, 1'b1);

    drive(1'b1, 1'b1, 16'h0F0F);
    idle(19, 1'b1);
    drive(1'b1, 1'b1, 16'hF0F0);
    idle(42, 1'b1);
    do_reset();
    idle(5, 1'b1);
    drive(1'b1, 1'b1, 16'h1234);
    idle(160, 1'b1);

    repeat (2500)
      drive($urandom_range(0, 19) != 0, $urandom_range(0, 69) == 0, 16'($urandom));
    idle(300, 1'b1);

    for (int i = 0; i < NI; i++) begin
      chk("frames_left", i, word_q[i].size(), 0);
      chk("overruns_left", i, ov_q[i].size(), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/tweezer_dac_writer.md
# tweezer_dac_writer

Serial DAC transmitter that sits downstream of the tweezer feedback controller. It accepts the controller's fixed-point output samples on a valid-strobed bus and converts each to offset binary when configured. It shifts each sample MSB-first into a 16-bit SPI-style DAC and pulses LDAC so the analog trap-drive output updates. A one-deep pending register decouples the controller's sample rate from the serial frame time: only the newest unsent sample is kept, and overwritten samples are flagged.

## Interface
- dataBitSize, 16, width of input sample and of the serial word
- clkDivider, 4, SCLK half-period in clk cycles (≥1)
- gapCycles, 2, minimum dac_cs_n high time between frames, in clk cycles (≥1)
- offsetBinary, 1, 1: invert MSB (two's complement → offset binary); 0: send raw
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  asynchronous, active-high reset
- enable  input  1  1: accept samples; 0: ignore new samples and drop pending
- inData  input  dataBitSize  signed sample from the feedback controller
- inData_valid  input  1  one-cycle strobe qualifying inData
- dac_cs_n  output  1  DAC chip select, active low
- dac_sclk  output  1  serial clock, idle low; DAC samples on rising edge
- dac_sdi  output  1  serial data, MSB first, changes only while dac_sclk low
- dac_ldac_n  output  1  DAC load strobe, active low
- busy  output  1  high whenever the FSM is not in IDLE
- overrun  output  1  one-cycle pulse when an unsent pending sample is overwritten or discarded

## Operation
- Word conversion: word = offsetBinary ? {~inData[MSB], inData[MSB-1:0]} : inData. For example, 0x0000→0x8000, 0x7FFF→0xFFFF, 0x8000→0x0000.
- FSM states: IDLE, SETUP, SHIFT, LOAD, GAP.
- IDLE:
  - If enable and inData_valid: load the shift register with the converted word and go to SETUP.
  - Otherwise, if a pending sample exists: load it, clear pending, and go to SETUP.
  - If a valid strobe and a pending sample coexist, the new sample wins. Pending is cleared and overrun pulses.
- SETUP: dac_cs_n=0, dac_sclk=0, dac_sdi=word MSB. Hold for clkDivider cycles, then go to SHIFT.
- SHIFT: dataBitSize bit periods of 2·clkDivider cycles each.
  - dac_sclk is high for the first clkDivider cycles of each period and low for the second.
  - On each high→low transition the register shifts and dac_sdi presents the next bit.
  - After the last bit's low phase, go to LOAD.
- LOAD: dac_cs_n=1, dac_ldac_n=0 for clkDivider cycles, then go to GAP.
- GAP: dac_cs_n=1, dac_ldac_n=1 for gapCycles cycles, then go to IDLE.
- Pending register:
  - In any state other than IDLE, enable && inData_valid stores the converted word and sets pending.
  - If pending was already set, the new word replaces the old one and overrun pulses.
- enable low:
  - Valid strobes are ignored.
  - An existing pending sample is cleared without an overrun pulse.
  - A frame in progress completes normally.
- All outputs are registered; no combinational path from inputs to outputs.
- Reset (async, any state, including mid-frame):
  - Outputs: dac_cs_n=1, dac_sclk=0, dac_sdi=0, dac_ldac_n=1, busy=0, overrun=0.
  - Internal: pending cleared, FSM returns to IDLE, counters cleared.
  - Frame aborted; no LDAC pulse.

## Timing
- Strobe sampled at edge k in IDLE: dac_cs_n low and busy high after edge k; first SCLK rise after edge k+clkDivider.
- Frame length from cs_n falling to returning to IDLE: clkDivider·(2·dataBitSize+2)+gapCycles. At defaults this is 4·34+2 = 138 cycles.
- Maximum sustained sample rate without overrun: one sample per frame length.
- Pending sample start: a pending sample begins one cycle after GAP ends, i.e. one IDLE cycle.
- Strobe on the last GAP cycle: goes to pending and is sent from the following IDLE cycle. It is not dropped.
- overrun timing: asserted for exactly one cycle, on the cycle after the offending strobe edge.
- SDI setup/hold: dac_sdi is stable for clkDivider cycles before and after every dac_sclk rising edge.

## Test plan
- Single sample 0x1234, defaults:
  - Shifted word is 0x9234 MSB-first: 16 SCLK rises, each sampled bit matches.
  - ldac_n low exactly 4 cycles after cs_n rises.
  - busy for 138 cycles.
- offsetBinary=0, inputs 0x8000 and 0x7FFF sent back-to-back with a strobe during frame 1:
  - Frames carry 0x8000 then 0x7FFF.
  - Second cs_n fall occurs one cycle after the first GAP ends.
  - No overrun.
- Three strobes (0x0001, 0x0002, 0x0003) at 10-cycle spacing: first frame sends 0x8001, then a single overrun pulse, then the second frame sends 0x8003.
- enable=0 with strobes in IDLE and mid-frame: no new frame starts, the in-progress frame completes, pending is discarded, and overrun never pulses.
- Async reset asserted mid-SHIFT (bit 7) with pending set:
  - Outputs take reset values immediately, with no further SCLK edges and no LDAC.
  - After release, the next strobe produces a clean full frame.
- clkDivider=1, gapCycles=1: frame is 35 cycles, and SCLK toggles every cycle with correct data alignment.
